pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the five-stage pipeline. It holds the program counter and selects the next PC from sequential, branch, jump, exception-vector and EPC-return sources. It drives the instruction-memory word address and the `IF_PC` consumed by the IF/ID register. It owns the EPC and exception-active state, a fetch counter and a boot/run/halt FSM.

## Interface
Parameters:
- `RESET_PC`, 30'h0000_0C00: word address loaded on reset (byte 0x3000).
- `EXC_VECTOR`, 30'h0000_1060: word address of exception handler (byte 0x4180).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Load_use`  in  1  load-use hazard; hold PC.
- `Jump`  in  1  jump resolved in ID.
- `Jump_target`  in  30  jump word address [31:2].
- `Branch`  in  1  taken branch resolved in ID.
- `Branch_target`  in  30  branch word address [31:2].
- `Exc_req`  in  1  syscall decoded in ID.
- `Eret`  in  1  ERET decoded in ID.
- `ID_PC`  in  30  PC of the instruction currently in ID.
- `Halt`  in  1  stop fetching until reset.
- `IF_PC`  out  30  current fetch word address; also the instruction-memory address.
- `fetch_valid`  out  1  `IF_PC` is a real fetch this cycle.
- `EPC`  out  30  saved exception PC.
- `Exc_active`  out  1  handler in progress.
- `Fetch_count`  out  32  number of PC advances since reset.
- `Halted`  out  1  FSM in HALT.

## Operation
FSM states are BOOT, RUN and HALT.
- BOOT: entered on reset. `fetch_valid`=0. Always goes to RUN on the next edge; the PC is not updated in BOOT.
- RUN: `fetch_valid`=1. Next-PC priority, highest first:
  1. `Halt`: go to HALT, PC unchanged.
  2. `Exc_req` with !`Exc_active`: PC<=`EXC_VECTOR`, `EPC`<=`ID_PC`+1, `Exc_active`<=1.
  3. `Eret` with `Exc_active`: PC<=`EPC`, `Exc_active`<=0.
  4. `Load_use`: PC held.
  5. `Jump`: PC<=`Jump_target`.
  6. `Branch`: PC<=`Branch_target`.
  7. Otherwise: PC<=PC+1.
- HALT: `fetch_valid`=0. PC, `EPC`, `Exc_active` and `Fetch_count` are frozen. Only reset exits.
- Exceptions do not nest. `Exc_req` while `Exc_active`=1 is ignored, and priority falls through to rules 4–7.
- `Eret` while `Exc_active`=0 is ignored and falls through to rules 4–7.
- `Exc_req` and `Eret` together: `Exc_req` wins if !`Exc_active`, otherwise `Eret` wins.
- `Exc_req` and `Eret` override `Load_use`; `Load_use` overrides `Jump` and `Branch`. ID re-asserts the redirect after the stall clears.
- `Jump` and `Branch` together: `Jump` wins.
- PC arithmetic is 30-bit modulo; 30'h3FFF_FFFF+1 wraps to 0.
- `Fetch_count` increments by 1 on every RUN edge where PC changes by any rule other than 1 or 4. It wraps at 2^32.

## Timing
- Reset values: `IF_PC`=`RESET_PC`, `fetch_valid`=0, `EPC`=0, `Exc_active`=0, `Fetch_count`=0, `Halted`=0, state=BOOT.
- Asserting `reset` mid-operation applies the reset values immediately (asynchronous). The first RUN edge is the second rising edge after deassertion.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Redirect latency is 1 cycle: a redirect input sampled at edge N gives the new `IF_PC` after edge N.
- The IF/ID register samples `IF_PC` on the falling edge of the same cycle, so `IF_PC` must be stable by mid-cycle.
- `Halted` rises and `fetch_valid` falls together, one edge after `Halt` is sampled.

## Test plan
- Reset, then 5 idle cycles: `IF_PC` goes 0xC00 (BOOT), 0xC00, 0xC01, 0xC02, 0xC03; `Fetch_count`=3; `fetch_valid` goes 0→1 after the first edge.
- At PC 0xC02, `Load_use` for 2 cycles with `Jump`=1 and `Jump_target`=0xD00: PC holds 0xC02 for both cycles. On the next cycle (`Jump` only), PC goes to 0xD00.
- `Exc_req` with `ID_PC`=0xC05: `IF_PC` goes to 0x1060, `EPC`=0xC06, `Exc_active`=1. A second `Exc_req` advances PC to 0x1061, `EPC` unchanged. Then `Eret`: `IF_PC`=0xC06, `Exc_active`=0.
- `Eret` with `Exc_active`=0 and `Branch`=1, `Branch_target`=0xE00: PC goes to 0xE00.
- PC forced to 0x3FFF_FFFF via jump, one idle cycle: PC=0, `Fetch_count` incremented.
- `Halt` at PC 0xC10: `Halted`=1, `fetch_valid`=0, PC stays 0xC10 for 10 cycles despite `Jump`. Asserting `reset` mid-cycle restores 0xC00 and BOOT immediately.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch PC unit: boot/run/halt sequencing, next-PC selection,
// exception entry/return bookkeeping and a count of PC advances.
module pc_fetch_unit #(
  parameter logic [29:0] RESET_PC   = 30'h0000_0C00,
  parameter logic [29:0] EXC_VECTOR = 30'h0000_1060
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Load_use,
  input  logic        Jump,
  input  logic [29:0] Jump_target,
  input  logic        Branch,
  input  logic [29:0] Branch_target,
  input  logic        Exc_req,
  input  logic        Eret,
  input  logic [29:0] ID_PC,
  input  logic        Halt,
  output logic [29:0] IF_PC,
  output logic        fetch_valid,
  output logic [29:0] EPC,
  output logic        Exc_active,
  output logic [31:0] Fetch_count,
  output logic        Halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [29:0] r_pc;
  logic [29:0] r_epc;
  logic        r_exc_active;
  logic [31:0] r_fetch_count;

  logic        w_take_exc;
  logic        w_take_eret;
  logic [29:0] w_next_pc;
  logic        w_advance;

  // Exceptions never nest; an ERET only counts while a handler is running.
  assign w_take_exc  = Exc_req & ~r_exc_active;
  assign w_take_eret = Eret & r_exc_active;

  always_comb begin
    w_next_pc = r_pc;
    w_advance = 1'b0;
    if (w_take_exc) begin
      w_next_pc = EXC_VECTOR;
      w_advance = 1'b1;
    end else if (w_take_eret) begin
      w_next_pc = r_epc;
      w_advance = 1'b1;
    end else if (Load_use) begin
      w_next_pc = r_pc;
      w_advance = 1'b0;
    end else if (Jump) begin
      w_next_pc = Jump_target;
      w_advance = 1'b1;
    end else if (Branch) begin
      w_next_pc = Branch_target;
      w_advance = 1'b1;
    end else begin
      w_next_pc = r_pc + 30'd1;
      w_advance = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_epc         <= 30'd0;
      r_exc_active  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (Halt) begin
            r_state <= ST_HALT;
          end else begin
            r_pc <= w_next_pc;
            if (w_take_exc) begin
              r_epc        <= ID_PC + 30'd1;
              r_exc_active <= 1'b1;
            end else if (w_take_eret) begin
              r_exc_active <= 1'b0;
            end
            if (w_advance) r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // Status outputs come straight from registers so the IF/ID latch sees a stable value.
  assign IF_PC       = r_pc;
  assign EPC         = r_epc;
  assign Exc_active  = r_exc_active;
  assign Fetch_count = r_fetch_count;
  assign fetch_valid = (r_state == ST_RUN);
  assign Halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Load_use, Jump, Branch, Exc_req, Eret, Halt;
  logic [29:0] Jump_target, Branch_target, ID_PC;
  logic [29:0] IF_PC, EPC;
  logic        fetch_valid, Exc_active, Halted;
  logic [31:0] Fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .Load_use(Load_use), .Jump(Jump),
    .Jump_target(Jump_target), .Branch(Branch), .Branch_target(Branch_target),
    .Exc_req(Exc_req), .Eret(Eret), .ID_PC(ID_PC), .Halt(Halt),
    .IF_PC(IF_PC), .fetch_valid(fetch_valid), .EPC(EPC), .Exc_active(Exc_active),
    .Fetch_count(Fetch_count), .Halted(Halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = booting, 1 = running, 2 = halted.
  int          m_phase;
  logic [29:0] m_pc, m_epc;
  bit          m_act;
  int unsigned m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_pc = 30'hC00; m_epc = 30'd0; m_act = 1'b0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (Halt) m_phase = 2;
      else if (Exc_req && !m_act) begin
        m_epc = ID_PC + 30'd1; m_pc = 30'h1060; m_act = 1'b1; m_cnt++;
      end else if (Eret && m_act) begin
        m_pc = m_epc; m_act = 1'b0; m_cnt++;
      end else if (Load_use) begin
        // held
      end else if (Jump) begin
        m_pc = Jump_target; m_cnt++;
      end else if (Branch) begin
        m_pc = Branch_target; m_cnt++;
      end else begin
        m_pc = m_pc + 30'd1; m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_IF_PC", {2'b0, IF_PC}, {2'b0, m_pc});
      check("model_EPC", {2'b0, EPC}, {2'b0, m_epc});
      check("model_Exc_active", {31'b0, Exc_active}, {31'b0, m_act});
      check("model_Fetch_count", Fetch_count, m_cnt);
      check("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, (m_phase == 1)});
      check("model_Halted", {31'b0, Halted}, {31'b0, (m_phase == 2)});
    end
  end

  task automatic idle_inputs();
    Load_use = 0; Jump = 0; Branch = 0; Exc_req = 0; Eret = 0; Halt = 0;
    Jump_target = '0; Branch_target = '0; ID_PC = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    Load_use = ($urandom_range(0, 3) == 0);
    Jump     = ($urandom_range(0, 3) == 0);
    Branch   = ($urandom_range(0, 2) == 0);
    Exc_req  = ($urandom_range(0, 7) == 0);
    Eret     = ($urandom_range(0, 7) == 0);
    Halt     = 1'b0;
    Jump_target   = ($urandom_range(0, 9) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
    Branch_target = 30'($urandom);
    ID_PC         = ($urandom_range(0, 5) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
  endtask

  int unsigned c0;

  initial begin
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    cmp_en = 1'b1;
    check("reset_IF_PC", {2'b0, IF_PC}, 32'hC00);
    check("reset_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    reset = 1'b0;

    // Idle run from boot.
    cyc(); check("boot_pc", {2'b0, IF_PC}, 32'hC00);
    check("boot_fv", {31'b0, fetch_valid}, 32'd1);
    cyc(); check("seq_pc1", {2'b0, IF_PC}, 32'hC01);
    cyc(); cyc(); check("seq_pc3", {2'b0, IF_PC}, 32'hC03);
    check("seq_count", Fetch_count, 32'd3);

    // Load_use overrides a pending jump.
    Jump = 1; Jump_target = 30'hC02; cyc();
    Load_use = 1; Jump_target = 30'hD00; cyc();
    check("lu_hold1", {2'b0, IF_PC}, 32'hC02);
    cyc(); check("lu_hold2", {2'b0, IF_PC}, 32'hC02);
    Load_use = 0; cyc(); check("lu_jump", {2'b0, IF_PC}, 32'hD00);

    // Exception entry, ignored nested request, return.
    idle_inputs(); Exc_req = 1; ID_PC = 30'hC05; cyc();
    check("exc_pc", {2'b0, IF_PC}, 32'h1060);
    check("exc_epc", {2'b0, EPC}, 32'hC06);
    check("exc_act", {31'b0, Exc_active}, 32'd1);
    ID_PC = 30'h777; cyc();
    check("exc_nest_pc", {2'b0, IF_PC}, 32'h1061);
    check("exc_nest_epc", {2'b0, EPC}, 32'hC06);
    Exc_req = 0; Eret = 1; cyc();
    check("eret_pc", {2'b0, IF_PC}, 32'hC06);
    check("eret_act", {31'b0, Exc_active}, 32'd0);
    Branch = 1; Branch_target = 30'hE00; cyc();
    check("eret_ignored_branch", {2'b0, IF_PC}, 32'hE00);

    // Wrap at the top of the word-address space.
    idle_inputs(); Jump = 1; Jump_target = 30'h3FFF_FFFF; cyc();
    c0 = Fetch_count;
    Jump = 0; cyc();
    check("wrap_pc", {2'b0, IF_PC}, 32'h0);
    check("wrap_count", Fetch_count, c0 + 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cyc();
    end

    // Halt freezes everything despite redirects.
    idle_inputs(); Jump = 1; Jump_target = 30'hC10; cyc();
    c0 = Fetch_count;
    Halt = 1; Jump_target = 30'h123; cyc();
    check("halt_halted", {31'b0, Halted}, 32'd1);
    check("halt_fv", {31'b0, fetch_valid}, 32'd0);
    Halt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("halt_pc", {2'b0, IF_PC}, 32'hC10);
    end
    check("halt_count", Fetch_count, c0);

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b1;
    #1;
    check("areset_pc", {2'b0, IF_PC}, 32'hC00);
    check("areset_halted", {31'b0, Halted}, 32'd0);
    check("areset_count", Fetch_count, 32'd0);
    cyc(); reset = 1'b0; idle_inputs();
    cyc(); check("rerun_pc", {2'b0, IF_PC}, 32'hC00);
    cyc(); check("rerun_pc1", {2'b0, IF_PC}, 32'hC01);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
